// File: rtl/data_mem_pkg.sv
// Shared funct3 encodings for loads and stores, plus a helper that maps a
// store's funct3 onto the byte lanes it writes.
package data_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Lane k set means byte a+k is written; unknown codes write nothing.
  function automatic logic [3:0] store_lanes(input logic [2:0] f3);
    logic [3:0] lanes;
    lanes = 4'b0000;
    case (f3)
      F3_B:    lanes = 4'b0001;
      F3_H:    lanes = 4'b0011;
      F3_W:    lanes = 4'b1111;
      default: lanes = 4'b0000;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/data_mem_if.sv
// MEM-stage access bus between the pipeline (master) and the data memory (slave).
interface data_mem_if;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  func3;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic [31:0] data_out;

  modport master (
    output MemRead, MemWrite, func3, addr, data_in,
    input  data_out
  );

  modport slave (
    input  MemRead, MemWrite, func3, addr, data_in,
    output data_out
  );
endinterface

// File: rtl/data_mem_load_extend.sv
// Turns the raw little-endian word gathered at the load address into the
// architectural load result (sign/zero extension by funct3).
module load_extend
  import data_mem_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [2:0]  func3,
  output logic [31:0] data_out
);

  // Select width and extension; reserved encodings read as zero.
  always_comb begin
    data_out = 32'h0000_0000;
    case (func3)
      F3_B:    data_out = {{24{raw[7]}}, raw[7:0]};
      F3_H:    data_out = {{16{raw[15]}}, raw[15:0]};
      F3_W:    data_out = raw;
      F3_BU:   data_out = {24'h000000, raw[7:0]};
      F3_HU:   data_out = {16'h0000, raw[15:0]};
      default: data_out = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/data_mem.sv
// Byte-addressed little-endian data memory: clocked byte-lane stores,
// combinational loads, addresses wrap modulo the memory size.
module data_mem
  import data_mem_pkg::*;
#(
  parameter int ADDR_BITS = 10
) (
  input  logic       clk,
  input  logic       rst,
  data_mem_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [7:0]           mem [DEPTH];
  logic [ADDR_BITS-1:0] lane_addr [4];
  logic [3:0]           lane_mask;
  logic [3:0]           lane_we;
  logic [31:0]          raw_word;
  logic [31:0]          load_data;
  logic                 unused_addr_bits;

  assign lane_mask = store_lanes(bus.func3);

  // Upper address bits are not decoded.
  assign unused_addr_bits = ^bus.addr[31:ADDR_BITS];

  // Each lane addresses a+k; the natural ADDR_BITS-wide add gives the wrap.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_addr[gi]       = bus.addr[ADDR_BITS-1:0] + ADDR_BITS'(gi);
      assign lane_we[gi]         = bus.MemWrite & lane_mask[gi];
      assign raw_word[8*gi +: 8] = mem[lane_addr[gi]];
    end
  endgenerate

  // Reset clears every byte and wins over a simultaneous store.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (lane_we[k]) begin
          mem[lane_addr[k]] <= bus.data_in[8*k +: 8];
        end
      end
    end
  end

  load_extend u_load_extend (
    .raw      (raw_word),
    .func3    (bus.func3),
    .data_out (load_data)
  );

  // No read enable means the bus carries zero.
  assign bus.data_out = bus.MemRead ? load_data : 32'h0000_0000;

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: directed cases from the access rules
// followed by randomized traffic compared against a byte-array model.
module tb_data_mem;

  localparam int ADDR_BITS = 10;
  localparam int DEPTH     = 1 << ADDR_BITS;

  logic clk;
  logic rst;
  data_mem_if bus ();

  data_mem #(.ADDR_BITS(ADDR_BITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  byte unsigned ref_mem [DEPTH];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic int unsigned ref_byte(input int unsigned a, input int k);
    return ref_mem[(a + k) % DEPTH];
  endfunction

  // Reference load computed from the architectural rules with plain arithmetic.
  function automatic logic [31:0] model_load(input logic rd, input logic [2:0] f3, input int unsigned a);
    int unsigned b0, half, word;
    if (!rd) return 32'h0;
    b0   = ref_byte(a, 0);
    half = b0 + 256 * ref_byte(a, 1);
    word = half + 65536 * ref_byte(a, 2) + 16777216 * ref_byte(a, 3);
    case (f3)
      3'd0: return (b0 >= 128) ? 32'(b0) - 32'd256 : 32'(b0);
      3'd1: return (half >= 32768) ? 32'(half) - 32'd65536 : 32'(half);
      3'd2: return 32'(word);
      3'd4: return 32'(b0);
      3'd5: return 32'(half);
      default: return 32'h0;
    endcase
  endfunction

  function automatic int store_size(input logic [2:0] f3);
    case (f3)
      3'd0: return 1;
      3'd1: return 2;
      3'd2: return 4;
      default: return 0;
    endcase
  endfunction

  // One bus cycle: drive at negedge, check the combinational output before the
  // edge against the model, then commit the model at the rising edge.
  task automatic step(input logic r, input logic w, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic rs, input string tag);
    @(negedge clk);
    bus.MemRead  = r;
    bus.MemWrite = w;
    bus.func3    = f3;
    bus.addr     = a;
    bus.data_in  = d;
    rst          = rs;
    #1;
    check_val(tag, bus.data_out, model_load(r, f3, a));
    @(posedge clk);
    if (rs) begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    end else if (w) begin
      for (int k = 0; k < store_size(f3); k++)
        ref_mem[(a + k) % DEPTH] = d[8*k +: 8];
    end
  endtask

  task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    step(1'b0, 1'b1, f3, a, d, 1'b0, "store_idle_out");
  endtask

  // Directed load against a hand-computed constant.
  task automatic expect_load(input logic rd, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] exp, input string tag);
    @(negedge clk);
    bus.MemRead  = rd;
    bus.MemWrite = 1'b0;
    bus.func3    = f3;
    bus.addr     = a;
    bus.data_in  = 32'h0;
    rst          = 1'b0;
    #1;
    check_val(tag, bus.data_out, exp);
  endtask

  initial begin
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.func3    = 3'd0;
    bus.addr     = 32'h0;
    bus.data_in  = 32'h0;
    rst          = 1'b1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    repeat (2) @(posedge clk);

    expect_load(1'b1, 3'd2, 32'd0,   32'h0, "reset_lw0");
    expect_load(1'b1, 3'd2, 32'd512, 32'h0, "reset_lw512");

    store(3'd2, 32'd0, 32'h0000_06F4);
    expect_load(1'b1, 3'd0, 32'd0, 32'hFFFF_FFF4, "lb_neg");
    expect_load(1'b1, 3'd4, 32'd0, 32'd244,       "lbu");

    store(3'd2, 32'd4, 32'h0004_E634);
    expect_load(1'b1, 3'd1, 32'd4, 32'hFFFF_E634, "lh_neg");
    expect_load(1'b1, 3'd5, 32'd4, 32'd58932,     "lhu");

    store(3'd2, 32'd0, 32'h0301_06F4);
    expect_load(1'b1, 3'd2, 32'd0, 32'h0301_06F4, "lw0");
    expect_load(1'b1, 3'd2, 32'd4, 32'h0004_E634, "lw4_kept");

    store(3'd0, 32'd9,  32'hFFFF_FFAB);
    store(3'd1, 32'd10, 32'hFFFF_1234);
    expect_load(1'b1, 3'd2, 32'd8, 32'h1234_AB00, "lw8_mixed");
    expect_load(1'b0, 3'd2, 32'd8, 32'h0,         "memread_low");
    expect_load(1'b1, 3'd2, 32'h0000_0808, 32'h1234_AB00, "upper_addr_ignored");
    expect_load(1'b1, 3'd0, 32'd9, 32'hFFFF_FFAB, "lb_misaligned");

    // Read-during-write: old data before the edge, new data after it.
    step(1'b1, 1'b1, 3'd2, 32'd8, 32'hCAFE_F00D, 1'b0, "rdw_before");
    expect_load(1'b1, 3'd2, 32'd8, 32'hCAFE_F00D, "rdw_after");

    // Reset with a simultaneous store: the store is dropped.
    step(1'b0, 1'b1, 3'd2, 32'd0, 32'hDEAD_BEEF, 1'b1, "rst_store");
    expect_load(1'b1, 3'd2, 32'd0, 32'h0, "rst_lw0");
    expect_load(1'b1, 3'd2, 32'd4, 32'h0, "rst_lw4");
    expect_load(1'b1, 3'd2, 32'd8, 32'h0, "rst_lw8");

    // Wrap across the top of memory.
    store(3'd2, 32'(DEPTH - 2), 32'h1122_3344);
    expect_load(1'b1, 3'd2, 32'd0,            32'h0000_1122, "wrap_low");
    expect_load(1'b1, 3'd2, 32'(DEPTH - 2),   32'h1122_3344, "wrap_lw");
    expect_load(1'b1, 3'd5, 32'(DEPTH - 1),   32'h0000_2233, "wrap_lhu");

    // Reserved funct3 codes.
    expect_load(1'b1, 3'd3, 32'd0, 32'h0, "ld_f3_011");
    expect_load(1'b1, 3'd6, 32'd0, 32'h0, "ld_f3_110");
    expect_load(1'b1, 3'd7, 32'd0, 32'h0, "ld_f3_111");
    store(3'd3, 32'd0, 32'hFFFF_FFFF);
    store(3'd6, 32'd0, 32'hFFFF_FFFF);
    store(3'd7, 32'd0, 32'hFFFF_FFFF);
    expect_load(1'b1, 3'd2, 32'd0, 32'h0000_1122, "st_reserved_nowrite");

    // Randomized traffic focused on a few hot regions so loads hit stores.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      logic [2:0]  f3;
      logic        r, w, rs;
      case ($urandom_range(0, 2))
        0:       a = 32'($urandom_range(0, 15));
        1:       a = 32'($urandom_range(DEPTH - 4, DEPTH - 1));
        default: a = 32'($urandom_range(0, DEPTH - 1));
      endcase
      a  = a | ($urandom() & 32'hFFFF_FC00);
      f3 = 3'($urandom_range(0, 7));
      r  = 1'($urandom_range(0, 3) != 0);
      w  = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 79) == 0);
      step(r, w, f3, a, $urandom(), rs, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/data_mem.md
# data_mem

Byte-addressed, little-endian data memory for the MEM stage of the pipelined RISC-V core. Executes RV32I loads (LB, LH, LW, LBU, LHU) and stores (SB, SH, SW), selected by the instruction's funct3. Writes are clocked; reads are combinational, so load data is available in the same cycle as the address.

## Interface
- ADDR_BITS, 10, number of byte-address bits decoded; memory holds 2^ADDR_BITS bytes (default 1 KiB).
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- MemRead  input  1  load enable; data_out is valid only while high.
- MemWrite  input  1  store enable; sampled on the rising edge of clk.
- func3  input  3  access type, taken from the instruction's funct3 field.
- addr  input  32  byte address; only addr[ADDR_BITS-1:0] is used.
- data_in  input  32  store data; the low byte, half or full word is written.
- data_out  output  32  load result after sign or zero extension.

## Operation
- Storage is an array of 2^ADDR_BITS bytes. Byte at address a+k holds bits [8k+7:8k] of a multi-byte value (little-endian).
- Address wraps modulo 2^ADDR_BITS, including the bytes of a multi-byte access that cross the top of memory.
- Misaligned half and word accesses are legal. They are handled byte-wise and generate no trap.

Stores (MemWrite=1, rising edge):
- func3=000 (SB): mem[a] <= data_in[7:0].
- func3=001 (SH): mem[a..a+1] <= data_in[15:0].
- func3=010 (SW): mem[a..a+3] <= data_in[31:0].
- Any other func3: no write.

Loads (MemRead=1, combinational):
- 000 (LB): sign-extend mem[a].
- 001 (LH): sign-extend {mem[a+1],mem[a]}.
- 010 (LW): {mem[a+3],mem[a+2],mem[a+1],mem[a]}.
- 100 (LBU): zero-extend mem[a].
- 101 (LHU): zero-extend the halfword.
- Any other func3 returns 0.
- MemRead=0 forces data_out = 0.

## Timing
- Load latency: 0 cycles. data_out follows addr, func3, MemRead and memory contents combinationally.
- Store latency: 1 edge. New contents are visible on data_out immediately after the edge that writes them.
- MemRead and MemWrite both high at the same address: data_out shows the old data before the edge and the new data after it. There is no bypass.
- Reset: on a rising edge with rst=1, every byte is cleared to 0.
  - Reset has priority over a simultaneous store, and that store is dropped.
  - After reset, any load returns 0.
- Reset asserted mid-sequence discards all earlier stores.
- No handshake and no stall: one access per cycle.

## Structure
- Shared package (e.g. `riscv_pkg`) holds the funct3 constants: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
- The same package is used by the control and decode blocks.
- One natural sub-module, `load_extend`: combinational, takes the 32-bit raw little-endian word and func3, and returns the extended data_out.
- The top level holds the byte array, the write-enable logic for each byte lane, and the reset clear.

## Test plan
- SW 0x000006F4 at addr 0, then LB at addr 0 -> data_out = 0xFFFFFFF4 (-12). LBU at addr 0 -> 244.
- SW 0x0004E634 at addr 4, then LH at addr 4 -> 0xFFFFE634 (-6604). LHU at addr 4 -> 58932.
- SW 0x030106F4 at addr 0, then LW at addr 0 -> 0x030106F4 (50398964). Check that LW at addr 4 is unchanged (0x0004E634).
- SB 0xAB at addr 9 and SH 0x1234 at addr 10, then LW at addr 8 -> 0x1234AB00. MemRead=0 -> data_out = 0.
- Assert rst together with a SW of 0xDEADBEEF at addr 0 -> LW at addr 0 returns 0, and all previously written words read 0.
- SW at addr 2^ADDR_BITS-2 wraps so its upper half lands at addr 0. Loads with func3=011 or 11x return 0, and stores with those codes leave memory unchanged.
